// File: rtl/aes_result_scanner.sv
// Byte-by-byte display scanner for a 128-bit AES result.
// Shows each byte for DWELL_CYCLES cycles and reports the equality check.
module aes_result_scanner #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         pause,
    input  logic [127:0] result_in,
    input  logic [127:0] expected_in,
    output logic [7:0]   byte_out,
    output logic [3:0]   byte_index,
    output logic         byte_valid,
    output logic         is_equal,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q;
    logic [127:0]     res_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             eq_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       idx_d;
    logic [7:0]       byte_d;

    // Byte k sits at bit 8*(15-k); ~idx_d is 15-idx_d for a 4-bit index.
    assign idx_d  = idx_q + 4'd1;
    assign byte_d = 8'(res_q >> {~idx_d, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= SCAN;
            res_q   <= result_in;
            eq_q    <= (result_in == expected_in);
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= result_in[127:120];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                SCAN: begin
                    if (!pause) begin
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (idx_q != 4'd15) begin
                                idx_q  <= idx_d;
                                byte_q <= byte_d;
                            end else begin
                                // Byte 15 stays on byte_out after the scan.
                                state_q <= DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_out   = byte_q;
    assign byte_index = idx_q;
    assign byte_valid = valid_q;
    assign is_equal   = eq_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
